// File: rtl/pe_bus_feeder.sv
// rtl/pe_bus_feeder.sv - burst reader that streams buffer words into one PE input FIFO
// Reads a (base, len) burst from a 1-cycle-latency buffer port and forwards words under PE backpressure.
module pe_bus_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  pe_fifo_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_en
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  reads_left;
  logic [LEN_WIDTH-1:0]  xfers_left;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  xfer;
  logic                  push;
  logic [2:0]            pending;

  assign xfer        = (occ != 2'd0) && !pe_fifo_full;
  assign data_out_en = xfer;
  assign data_out    = head;
  assign push        = inflight;
  assign cmd_busy    = (state != ST_IDLE);
  assign done        = (state == ST_FINISH);

  // Count the word popping this cycle as free space so a steady stream never bubbles.
  assign pending   = {1'b0, occ} + {2'b00, inflight};
  assign mem_rd_en = (state == ST_RUN) && (reads_left != '0) &&
                     (pending < (3'd2 + {2'b00, xfer}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      reads_left  <= '0;
      xfers_left  <= '0;
      mem_rd_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            mem_rd_addr <= cmd_base;
            reads_left  <= cmd_len;
            xfers_left  <= cmd_len;
            state       <= (cmd_len == '0) ? ST_FINISH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (mem_rd_en) begin
            mem_rd_addr <= mem_rd_addr + ADDR_ONE;
            reads_left  <= reads_left - LEN_ONE;
          end
          if (xfer) begin
            xfers_left <= xfers_left - LEN_ONE;
            if (xfers_left == LEN_ONE) state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry shift buffer: head feeds data_out and keeps its value once drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= mem_rd_en;
      case ({push, xfer})
        2'b10: begin
          if (occ == 2'd0) head <= mem_rd_data;
          else             tail <= mem_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) head <= tail;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head <= tail;
            tail <= mem_rd_data;
          end else begin
            head <= mem_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst) occ != 2'd3);

endmodule

// File: tb/tb_pe_bus_feeder.sv
// tb/tb_pe_bus_feeder.sv - randomized self-checking bench for pe_bus_feeder
module tb_pe_bus_feeder;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_start = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          pe_fifo_full = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_out_en;

  logic [DW-1:0] mem [0:1023];
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  logic log_en = 1'b0;
  int bp_viol = 0;
  logic [DW-1:0] xw[$];
  int            xc[$];
  logic [AW-1:0] ra[$];
  int            dc[$];
  logic [DW-1:0] exp_w[$];
  logic [AW-1:0] exp_a[$];
  bit full_mask [0:511];

  pe_bus_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .cmd_busy(cmd_busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .pe_fifo_full(pe_fifo_full), .data_out(data_out),
    .data_out_en(data_out_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(negedge clk) begin
    if (log_en) begin
      if (data_out_en) begin
        xw.push_back(data_out);
        xc.push_back(cyc);
        if (pe_fifo_full) bp_viol++;
      end
      if (mem_rd_en) ra.push_back(mem_rd_addr);
      if (done) dc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    xw.delete(); xc.delete(); ra.delete(); dc.delete();
    bp_viol = 0;
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 512; i++) full_mask[i] = 1'b0;
  endtask

  // Reference: a burst reads base, base+1, ... modulo 2^AW and delivers those words in order.
  task automatic model(input int base, input int len);
    exp_w.delete(); exp_a.delete();
    for (int i = 0; i < len; i++) begin
      exp_a.push_back(AW'((base + i) % 1024));
      exp_w.push_back(mem[(base + i) % 1024]);
    end
  endtask

  task automatic run_burst(input int base, input int len, input bit inj, output bit ok);
    clear_logs();
    log_en = 1'b1;
    @(posedge clk); #1;
    cmd_base = AW'(base); cmd_len = LW'(len); cmd_start = 1'b1;
    c0 = cyc + 1;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      cmd_start = inj && (k == 1);
      if (inj && k == 1) begin cmd_base = AW'(100); cmd_len = LW'(3); end
      pe_fifo_full = (k < 512) ? full_mask[k] : 1'b0;
      if (dc.size() > 0) begin ok = 1'b1; break; end
    end
    cmd_start = 1'b0; pe_fifo_full = 1'b0;
    repeat (4) @(posedge clk);
    #1 log_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cmd_busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", cmd_busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (mem_rd_en !== 1'b0) begin errs++; $display("FAIL rst_rd_en: got %b expected 0", mem_rd_en); end
    checks++; if (mem_rd_addr !== '0) begin errs++; $display("FAIL rst_rd_addr: got %0d expected 0", mem_rd_addr); end
    checks++; if (data_out !== '0) begin errs++; $display("FAIL rst_data_out: got %0h expected 0", data_out); end
    checks++; if (data_out_en !== 1'b0) begin errs++; $display("FAIL rst_data_out_en: got %b expected 0", data_out_en); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    for (int a = 0; a < 1024; a++) mem[a] = DW'(a + 1);
    clear_mask();
    run_burst(0, 6, 1'b0, ok);
    checks++; if (!ok) begin errs++; $display("FAIL t1_timeout: got no done expected done"); end
    checks++; if (xw.size() !== 6) begin errs++; $display("FAIL t1_count: got %0d expected 6", xw.size()); end
    for (int i = 0; i < xw.size() && i < 6; i++) begin
      checks++; if (xw[i] !== DW'(i + 1)) begin errs++; $display("FAIL t1_word[%0d]: got %0d expected %0d", i, xw[i], i + 1); end
      checks++; if (xc[i] !== c0 + 2 + i) begin errs++; $display("FAIL t1_xfer_cycle[%0d]: got %0d expected %0d", i, xc[i] - c0, 2 + i); end
    end
    checks++; if (ra.size() !== 6) begin errs++; $display("FAIL t1_reads: got %0d expected 6", ra.size()); end
    checks++; if (dc.size() !== 1) begin errs++; $display("FAIL t1_done_count: got %0d expected 1", dc.size()); end
    if (dc.size() > 0) begin
      checks++; if (dc[0] !== c0 + 8) begin errs++; $display("FAIL t1_done_cycle: got %0d expected 8", dc[0] - c0); end
    end
    checks++; if (cmd_busy !== 1'b0) begin errs++; $display("FAIL t1_busy_after: got %b expected 0", cmd_busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stalled;
    clear_mask();
    full_mask[4] = 1'b1; full_mask[5] = 1'b1;
    run_burst(0, 6, 1'b0, ok);
    stalled = 0;
    foreach (xc[i]) if (xc[i] == c0 + 4 || xc[i] == c0 + 5) stalled++;
    checks++; if (!ok) begin errs++; $display("FAIL t2_timeout: got no done expected done"); end
    checks++; if (bp_viol !== 0) begin errs++; $display("FAIL t2_en_while_full: got %0d expected 0", bp_viol); end
    checks++; if (stalled !== 0) begin errs++; $display("FAIL t2_stall_window: got %0d xfers expected 0", stalled); end
    checks++; if (xw.size() !== 6) begin errs++; $display("FAIL t2_count: got %0d expected 6", xw.size()); end
    for (int i = 0; i < xw.size() && i < 6; i++) begin
      checks++; if (xw[i] !== DW'(i + 1)) begin errs++; $display("FAIL t2_word[%0d]: got %0d expected %0d", i, xw[i], i + 1); end
    end
    if (dc.size() > 0 && xc.size() > 0) begin
      checks++; if (dc[0] !== xc[xc.size()-1] + 1) begin errs++; $display("FAIL t2_done_cycle: got %0d expected %0d", dc[0], xc[xc.size()-1] + 1); end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_mask();
    run_burst(5, 0, 1'b0, ok);
    checks++; if (ra.size() !== 0) begin errs++; $display("FAIL t3_reads: got %0d expected 0", ra.size()); end
    checks++; if (xw.size() !== 0) begin errs++; $display("FAIL t3_xfers: got %0d expected 0", xw.size()); end
    checks++; if (dc.size() !== 1) begin errs++; $display("FAIL t3_done_count: got %0d expected 1", dc.size()); end
    if (dc.size() > 0) begin
      checks++; if (dc[0] !== c0) begin errs++; $display("FAIL t3_done_cycle: got %0d expected 0", dc[0] - c0); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int a = 0; a < 1024; a++) mem[a] = DW'($urandom);
    clear_mask();
    model(1022, 4);
    run_burst(1022, 4, 1'b0, ok);
    checks++; if (ra.size() !== 4) begin errs++; $display("FAIL t4_reads: got %0d expected 4", ra.size()); end
    for (int i = 0; i < ra.size() && i < 4; i++) begin
      checks++; if (ra[i] !== exp_a[i]) begin errs++; $display("FAIL t4_addr[%0d]: got %0d expected %0d", i, ra[i], exp_a[i]); end
    end
    checks++; if (xw.size() !== 4) begin errs++; $display("FAIL t4_count: got %0d expected 4", xw.size()); end
    for (int i = 0; i < xw.size() && i < 4; i++) begin
      checks++; if (xw[i] !== exp_w[i]) begin errs++; $display("FAIL t4_word[%0d]: got %0h expected %0h", i, xw[i], exp_w[i]); end
    end
  endtask

  task automatic test_busy_cmd();
    bit ok;
    for (int a = 0; a < 1024; a++) mem[a] = DW'(a + 1);
    clear_mask();
    run_burst(0, 6, 1'b1, ok);
    checks++; if (xw.size() !== 6) begin errs++; $display("FAIL t5_count: got %0d expected 6", xw.size()); end
    for (int i = 0; i < xw.size() && i < 6; i++) begin
      checks++; if (xw[i] !== DW'(i + 1)) begin errs++; $display("FAIL t5_word[%0d]: got %0d expected %0d", i, xw[i], i + 1); end
    end
    checks++; if (ra.size() !== 6) begin errs++; $display("FAIL t5_reads: got %0d expected 6", ra.size()); end
    checks++; if (dc.size() !== 1) begin errs++; $display("FAIL t5_done_count: got %0d expected 1", dc.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    clear_logs();
    log_en = 1'b1;
    @(posedge clk); #1;
    cmd_base = '0; cmd_len = LW'(8); cmd_start = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0;
    k = 0;
    while (xw.size() < 3 && k < 50) begin @(posedge clk); #1; k++; end
    checks++; if (xw.size() !== 3) begin errs++; $display("FAIL t6_pre_words: got %0d expected 3", xw.size()); end
    rst = 1'b0;
    #1;
    checks++; if ({cmd_busy, done, mem_rd_en, data_out_en} !== 4'b0000) begin errs++; $display("FAIL t6_ctrl_reset: got %b expected 0000", {cmd_busy, done, mem_rd_en, data_out_en}); end
    checks++; if (data_out !== '0 || mem_rd_addr !== '0) begin errs++; $display("FAIL t6_data_reset: got %0h/%0d expected 0/0", data_out, mem_rd_addr); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dc.size() !== 0) begin errs++; $display("FAIL t6_no_done: got %0d expected 0", dc.size()); end
    checks++; if (xw.size() !== 3) begin errs++; $display("FAIL t6_no_extra: got %0d expected 3", xw.size()); end
    log_en = 1'b0;
    clear_mask();
    run_burst(50, 2, 1'b0, ok);
    checks++; if (xw.size() !== 2) begin errs++; $display("FAIL t6_new_count: got %0d expected 2", xw.size()); end
    for (int i = 0; i < xw.size() && i < 2; i++) begin
      checks++; if (xw[i] !== DW'(51 + i)) begin errs++; $display("FAIL t6_new_word[%0d]: got %0d expected %0d", i, xw[i], 51 + i); end
      checks++; if (xc[i] !== c0 + 2 + i) begin errs++; $display("FAIL t6_new_cycle[%0d]: got %0d expected %0d", i, xc[i] - c0, 2 + i); end
    end
    checks++; if (dc.size() !== 1) begin errs++; $display("FAIL t6_new_done: got %0d expected 1", dc.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int base, len, bad_w, bad_a;
    for (int a = 0; a < 1024; a++) mem[a] = DW'($urandom);
    for (int n = 0; n < 12; n++) begin
      base = $urandom_range(0, 1023);
      len = $urandom_range(0, 40);
      for (int i = 0; i < 512; i++) full_mask[i] = ($urandom_range(0, 2) == 0);
      model(base, len);
      run_burst(base, len, 1'b0, ok);
      bad_w = 0; bad_a = 0;
      for (int i = 0; i < xw.size() && i < len; i++) if (xw[i] !== exp_w[i]) bad_w++;
      for (int i = 0; i < ra.size() && i < len; i++) if (ra[i] !== exp_a[i]) bad_a++;
      checks++; if (!ok) begin errs++; $display("FAIL rnd%0d_timeout: got no done expected done", n); end
      checks++; if (xw.size() !== len || bad_w !== 0) begin errs++; $display("FAIL rnd%0d_words: got %0d words %0d wrong expected %0d words", n, xw.size(), bad_w, len); end
      checks++; if (ra.size() !== len || bad_a !== 0) begin errs++; $display("FAIL rnd%0d_addrs: got %0d reads %0d wrong expected %0d reads", n, ra.size(), bad_a, len); end
      checks++; if (bp_viol !== 0) begin errs++; $display("FAIL rnd%0d_en_while_full: got %0d expected 0", n, bp_viol); end
      checks++; if (dc.size() !== 1) begin errs++; $display("FAIL rnd%0d_done_count: got %0d expected 1", n, dc.size()); end
      if (dc.size() > 0) begin
        checks++;
        if (dc[0] !== ((len == 0 || xc.size() == 0) ? c0 : xc[xc.size()-1] + 1)) begin
          errs++; $display("FAIL rnd%0d_done_cycle: got %0d (len %0d)", n, dc[0] - c0, len);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_busy_cmd();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
